serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell: sum = a^b^cin, carry = majority(a,b,cin).
- Accepts two WIDTH-bit operands on a start pulse.
- Steps the cell once per clock, LSB first, holding the carry in a flip-flop between steps.
- Presents the registered result with carry and signed-overflow flags.
- Serves as the area-minimal arithmetic unit for control paths where latency is cheap.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only in IDLE or DONE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
op_a  input  WIDTH  operand A; sampled with start
op_b  input  WIDTH  operand B; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result and flags valid from this cycle
result  output  WIDTH  registered sum/difference
carry_out  output  1  final carry; for subtract, 1 = no borrow (A >= B unsigned)
overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: clk is one clock; rst_n is asynchronous, active-low.
  - Reset takes effect immediately regardless of clk.
  - State=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, bit counter=0, all shift registers and carry FF = 0.
- States are IDLE, RUN and DONE.
- IDLE: busy=0, done=0.
  - start=1 at an edge loads sha<=op_a, shb<=(sub ? ~op_b : op_b), carry FF<=sub, count<=0, then moves to RUN.
  - sub and operands are captured only at that edge; later input changes have no effect.
- RUN: busy=1. At each edge:
  - Full-adder cell inputs are sha[0], shb[0] and the carry FF.
  - The sum bit shifts into the MSB of the sum shift register (right shift). sha and shb shift right.
  - Carry FF <= cell carry. count increments.
  - The edge processing bit WIDTH-2 also stores the cell carry as cmsb (carry into MSB).
  - On the edge processing bit WIDTH-1 (count == WIDTH-1):
    - result <= completed sum register, including this final bit;
    - carry_out <= cell carry;
    - overflow <= cmsb ^ cell carry;
    - state -> DONE.
  - start is ignored in RUN; no queueing.
- DONE: done=1 for exactly this one cycle, busy=0.
  - Next edge: if start=1, load as from IDLE and go to RUN (back-to-back); otherwise go to IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Output hold: result, carry_out and overflow change only at the completion edge. They hold the previous value during RUN and after DONE until the next completion.
- Width rules: all arithmetic is modulo 2^WIDTH. Counter width is clog2(WIDTH).
- Reset mid-RUN aborts: no done pulse, and outputs go to 0.
- Start asserted for multiple cycles in IDLE starts exactly one operation. A start still high in DONE starts a second operation (intended).

Test Plan:
1. WIDTH=8, sub=0, A=0x35, B=0x4A, one-cycle start -> busy high for 8 cycles, done in cycle 9 after the start edge, result=0x7F, carry_out=0, overflow=0.
2. Add A=0xFF, B=0x01 -> result=0x00, carry_out=1, overflow=0. Then add A=0x7F, B=0x01 -> result=0x80, carry_out=0, overflow=1.
3. Subtract A=0x10, B=0x20 -> result=0xF0, carry_out=0 (borrow), overflow=0. Subtract A=0x80, B=0x01 -> result=0x7F, carry_out=1, overflow=1.
4. Start 0x01+0x01, then pulse start with A=0xAA, B=0x55 in RUN cycle 3, and change op_a mid-RUN -> single done, result=0x02. The second start is ignored and no second done follows.
5. Start held high across DONE: first op 0x0F+0x01, second captured at the DONE edge -> done pulses exactly WIDTH+1 cycles apart. result=0x10 is held until the second completion.
6. Assert rst_n=0 mid-RUN, asynchronously between edges -> busy, done, result and flags go to 0 immediately and state returns to IDLE. After release, 0x03+0x04 gives 0x07 with normal latency.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract through one full-adder cell, LSB first
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PEN  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sha_q, shb_q, result_q;
    logic [WIDTH-2:0] shs_q;
    logic [CW-1:0]    cnt_q;
    logic             cy_q, cmsb_q, busy_q, done_q, cout_q, ovf_q;
    logic             sum_bit, cell_cy;
    logic [WIDTH-1:0] shs_d;

    // full-adder cell; shs_d is the sum register with this step's bit shifted into the MSB
    always_comb begin
        sum_bit = sha_q[0] ^ shb_q[0] ^ cy_q;
        cell_cy = (sha_q[0] & shb_q[0]) | (sha_q[0] & cy_q) | (shb_q[0] & cy_q);
        shs_d   = {sum_bit, shs_q};
    end

    // sequencer and datapath; subtraction is a + ~b with the carry seeded to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sha_q    <= '0;
            shb_q    <= '0;
            shs_q    <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            cmsb_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    sha_q <= sha_q >> 1;
                    shb_q <= shb_q >> 1;
                    shs_q <= shs_d[WIDTH-1:1];
                    cy_q  <= cell_cy;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == PEN) cmsb_q <= cell_cy;
                    if (cnt_q == LAST) begin
                        result_q <= shs_d;
                        cout_q   <= cell_cy;
                        ovf_q    <= cmsb_q ^ cell_cy;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sha_q   <= op_a;
                        shb_q   <= sub ? ~op_b : op_b;
                        cy_q    <= sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table, random and corner-sequence checks of the serial adder
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int           pass_cnt = 0, total = 0;
    logic [W-1:0] last_res = '0;

    typedef struct {
        logic         s;
        logic [W-1:0] a, b, r;
        logic         c, v;
    } vec_t;

    vec_t tbl[8];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // reference: plain unsigned and signed integer arithmetic
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v);
        longint m  = longint'(1) << W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint ur = s ? ua - ub : ua + ub;
        longint sr = s ? sa - sb : sa + sb;
        r = W'(((ur % m) + m) % m);
        c = s ? (ua >= ub) : (ur >= m);
        v = (sr >= m / 2) || (sr < -(m / 2));
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic ev, input string tag);
        int cyc = 1;
        int busyc = 0;
        @(negedge clk);
        start = 1'b1; sub = s; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; sub = ~s; op_a = ~a; op_b = ~b;
        chk({tag, " hold"}, result, last_res);
        while (!done && cyc < 4 * W) begin
            if (busy) busyc++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, W + 1);
        chk({tag, " busy_cycles"}, busyc, W);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_in_done"}, busy, 0);
        chk({tag, " result"}, result, er);
        chk({tag, " carry"}, carry_out, ec);
        chk({tag, " ovf"}, overflow, ev);
        last_res = er;
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        int cyc, dones, busyc, d1, d2;
        logic         s, c, v;
        logic [W-1:0] a, b, r;
        tbl[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};

        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset carry", carry_out, 0);
        chk("reset ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].c, tbl[i].v, $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            model(s, a, b, r, c, v);
            run_op(s, a, b, r, c, v, $sformatf("rnd%0d", i));
        end

        // start pulsed and operands changed mid-RUN are ignored
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op_a = 8'h01; op_b = 8'h01;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        @(negedge clk);
        cyc++;
        @(negedge clk);
        cyc++; start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
        @(negedge clk);
        cyc++; start = 1'b0; op_a = 8'hFF;
        while (!done && cyc < 4 * W) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrun latency", cyc, W + 1);
        chk("midrun result", result, 8'h02);
        chk("midrun carry", carry_out, 0);
        chk("midrun ovf", overflow, 0);
        last_res = 8'h02;
        dones = 0; busyc = 0;
        repeat (3 * W) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busyc++;
        end
        chk("midrun extra_done", dones, 0);
        chk("midrun extra_busy", busyc, 0);

        // start held through DONE launches a back-to-back operation
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op_a = 8'h0F; op_b = 8'h01;
        @(negedge clk);
        op_a = 8'h20; op_b = 8'h03;
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 3 * W; k++) begin
            if (done) begin
                if (d1 == 0) begin
                    d1 = k;
                    chk("b2b first result", result, 8'h10);
                end else if (d2 == 0) begin
                    d2 = k;
                    chk("b2b second result", result, 8'h23);
                end
            end
            if (k == W + 2) start = 1'b0;
            if (k == W + 6) begin
                chk("b2b hold result", result, 8'h10);
                chk("b2b second busy", busy, 1);
            end
            @(negedge clk);
        end
        chk("b2b first latency", d1, W + 1);
        chk("b2b spacing", d2 - d1, W + 1);
        last_res = 8'h23;

        // asynchronous reset between edges aborts a running operation
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op_a = 8'h7F; op_b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset busy", busy, 1);
        chk("pre_reset result", result, 8'h23);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", busy, 0);
        chk("async done", done, 0);
        chk("async result", result, 0);
        chk("async carry", carry_out, 0);
        chk("async ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        run_op(1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, "post_reset");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
